// File: rtl/bpsk_qpsk_stream_mod.sv
// Streaming BPSK/QPSK symbol mapper.
//
// Accepts one N-bit codeword over a valid/ready handshake and serialises it,
// LSB first, into signed W-bit antipodal symbols (bit 0 -> +1, bit 1 -> -1,
// pad -> 0). BPSK emits N symbols on I only; QPSK emits ceil(N/2) symbols
// carrying two bits each (I = even bit, Q = odd bit).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    codeword, bit 0 transmitted first
//   in_valid   in_data / in_mode valid
//   in_ready   block can accept a codeword (combinational)
//   in_mode    0 = BPSK, 1 = QPSK, sampled on acceptance
//   sym_i      in-phase symbol (registered)
//   sym_q      quadrature symbol (registered)
//   out_valid  sym_i / sym_q / out_last valid (registered)
//   out_ready  downstream accepts the current symbol
//   out_last   final symbol of the codeword (registered)
module bpsk_qpsk_stream_mod #(
   parameter int N = 12,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_mode,
   output logic [W-1:0] sym_i,
   output logic [W-1:0] sym_q,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last
);

   localparam int CW = $clog2(N + 1);
   localparam int NQ = (N + 1) / 2;
   localparam logic [CW-1:0] LAST_B = CW'(N - 1);
   localparam logic [CW-1:0] LAST_Q = CW'(NQ - 1);
   localparam bit N_ODD = ((N % 2) == 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Antipodal mapping of one code bit to a W-bit two's-complement amplitude.
   function automatic logic [W-1:0] map_bit(input logic b);
      logic [W-1:0] v;
      if (b) begin
         v = {W{1'b1}};
      end else begin
         v = {{(W-1){1'b0}}, 1'b1};
      end
      return v;
   endfunction

   state_t        state_r;
   state_t        state_nx_s;
   logic [N-1:0]  data_r;      // bits not yet transmitted, next bit at [0]
   logic [N-1:0]  data_nx_s;
   logic          mode_r;
   logic          mode_nx_s;
   logic [CW-1:0] cnt_r;       // index of the symbol currently presented
   logic [CW-1:0] cnt_nx_s;
   logic [W-1:0]  sym_i_nx_s;
   logic [W-1:0]  sym_q_nx_s;
   logic          out_valid_nx_s;
   logic          out_last_nx_s;

   logic          fire_s;
   logic          accept_s;
   logic [N-1:0]  src_s;
   logic [N-1:0]  shift1_s;
   logic          src_mode_s;
   logic [CW-1:0] k_s;
   logic          last_k_s;
   logic          pad_s;

   // Handshake decode and computation of the next symbol to present.
   // The next symbol comes either from a freshly accepted codeword (index 0)
   // or from the remaining bits of the current one (index cnt+1).
   always_comb begin
      fire_s   = out_valid && out_ready;
      in_ready = !rst && ((state_r == IDLE) || (fire_s && out_last));
      accept_s = in_valid && in_ready;

      if (accept_s) begin
         src_s      = in_data;
         src_mode_s = in_mode;
         k_s        = {CW{1'b0}};
      end else begin
         src_s      = data_r;
         src_mode_s = mode_r;
         k_s        = cnt_r + CW'(1'b1);
      end

      shift1_s = src_s >> 1;
      if (src_mode_s) begin
         last_k_s = (k_s == LAST_Q);
      end else begin
         last_k_s = (k_s == LAST_B);
      end
      // Odd N in QPSK: the last symbol has no partner bit for Q.
      pad_s = src_mode_s && N_ODD && (k_s == LAST_Q);
   end

   // Next-state and next-output logic for the two-state serialiser.
   always_comb begin
      state_nx_s     = state_r;
      data_nx_s      = data_r;
      mode_nx_s      = mode_r;
      cnt_nx_s       = cnt_r;
      sym_i_nx_s     = sym_i;
      sym_q_nx_s     = sym_q;
      out_valid_nx_s = out_valid;
      out_last_nx_s  = out_last;

      case (state_r)
         IDLE, SEND: begin
            if (accept_s || (fire_s && !out_last)) begin
               // Load a new codeword or advance to the next symbol.
               state_nx_s     = SEND;
               mode_nx_s      = src_mode_s;
               cnt_nx_s       = k_s;
               sym_i_nx_s     = map_bit(src_s[0]);
               if (!src_mode_s || pad_s) begin
                  sym_q_nx_s = {W{1'b0}};
               end else begin
                  sym_q_nx_s = map_bit(shift1_s[0]);
               end
               if (src_mode_s) begin
                  data_nx_s = shift1_s >> 1;
               end else begin
                  data_nx_s = shift1_s;
               end
               out_valid_nx_s = 1'b1;
               out_last_nx_s  = last_k_s;
            end else if (fire_s && out_last) begin
               // Codeword finished with nothing waiting: drain to IDLE.
               state_nx_s     = IDLE;
               data_nx_s      = {N{1'b0}};
               cnt_nx_s       = {CW{1'b0}};
               sym_i_nx_s     = {W{1'b0}};
               sym_q_nx_s     = {W{1'b0}};
               out_valid_nx_s = 1'b0;
               out_last_nx_s  = 1'b0;
            end else begin
               // Stalled or idle: hold everything.
               state_nx_s = state_r;
            end
         end
         default: begin
            state_nx_s     = IDLE;
            data_nx_s      = {N{1'b0}};
            mode_nx_s      = 1'b0;
            cnt_nx_s       = {CW{1'b0}};
            sym_i_nx_s     = {W{1'b0}};
            sym_q_nx_s     = {W{1'b0}};
            out_valid_nx_s = 1'b0;
            out_last_nx_s  = 1'b0;
         end
      endcase
   end

   // State, shift register, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         data_r    <= {N{1'b0}};
         mode_r    <= 1'b0;
         cnt_r     <= {CW{1'b0}};
         sym_i     <= {W{1'b0}};
         sym_q     <= {W{1'b0}};
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         data_r    <= data_nx_s;
         mode_r    <= mode_nx_s;
         cnt_r     <= cnt_nx_s;
         sym_i     <= sym_i_nx_s;
         sym_q     <= sym_q_nx_s;
         out_valid <= out_valid_nx_s;
         out_last  <= out_last_nx_s;
      end
   end

endmodule
